// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
//   Handshake and result bundle for the sequential binary-to-BCD converter.
//
//   Signals:
//     in_valid   number is valid this cycle              (master -> slave)
//     number     binary value to convert, WIDTH bits     (master -> slave)
//     in_ready   converter idle, can accept              (slave  -> master)
//     out_valid  one-cycle pulse, bcd/negative updated   (slave  -> master)
//     bcd        packed BCD, digit 0 (ones) in [3:0]     (slave  -> master)
//     negative   sign of last result                     (slave  -> master)
//     busy       conversion in progress (== ~in_ready)   (slave  -> master)
//
//   Modports:
//     master  upstream producer / display consumer side
//     slave   converter side
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      number;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;
    logic                  busy;

    modport master (
        output in_valid,
        output number,
        input  in_ready,
        input  out_valid,
        input  bcd,
        input  negative,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  number,
        output in_ready,
        output out_valid,
        output bcd,
        output negative,
        output busy
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one input bit per clock. Presents registered, stable BCD digits to the
//   seven-segment driver so no combinational divide/modulo is needed there.
//   A new value is accepted over a valid/ready handshake; the last result is
//   held until the next conversion completes.
//
//   Parameters:
//     WIDTH   binary input width; one shift step per bit
//     DIGITS  number of BCD output digits; 10**DIGITS must exceed 2**WIDTH-1
//
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous, active-low reset
//     bus     bin_to_bcd_seq_if.slave (in_valid/in_ready/number in,
//             out_valid/bcd/negative/busy out)
//
//   Configuration:
//     BCD_SIGNED_EN  when defined, number is two's complement; the magnitude
//                    is converted and the sign is reported on negative.
//                    When undefined, number is unsigned and negative is 0.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int STEP_W = BCD_W + WIDTH;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MAX_STEP  = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [WIDTH-1:0]    shift_q,     shift_d;
    logic [BCD_W-1:0]    scratch_q,   scratch_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [BCD_W-1:0]    bcd_q,       bcd_d;
    logic                out_valid_q, out_valid_d;
`ifdef BCD_SIGNED_EN
    logic                sign_q,      sign_d;
    logic                negative_q,  negative_d;
`endif

    logic [WIDTH-1:0]    magnitude;
    logic [BCD_W-1:0]    scratch_adj;
    logic [STEP_W-1:0]   step_vec;

    // Pre-shift correction: any digit of 5 or more would become >= 10 after
    // doubling, so bump it by 3 to make the shift carry into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       digit;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            digit = s[4*d +: 4];
            if (digit >= 4'd5) begin
                digit = digit + 4'd3;
            end
            r[4*d +: 4] = digit;
        end
        return r;
    endfunction

    // Value loaded into the shift register at the accepting edge.
    always_comb begin
`ifdef BCD_SIGNED_EN
        // Two's-complement negate; the most-negative code maps to its
        // unsigned magnitude (e.g. 8'h80 -> 128) because WIDTH bits suffice.
        if (bus.number[WIDTH-1]) begin
            magnitude = ~bus.number + WIDTH'(1);
        end else begin
            magnitude = bus.number;
        end
`else
        magnitude = bus.number;
`endif
    end

    // One double-dabble step: correct digits, then shift {scratch, shift}.
    always_comb begin
        scratch_adj = add3_digits(scratch_q);
        step_vec    = {scratch_adj, shift_q} << 1;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = 1'b0;
`ifdef BCD_SIGNED_EN
        sign_d      = sign_q;
        negative_d  = negative_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // in_ready is implied by being in IDLE.
                if (bus.in_valid) begin
                    shift_d   = magnitude;
                    scratch_d = '0;
                    cnt_d     = '0;
`ifdef BCD_SIGNED_EN
                    sign_d    = bus.number[WIDTH-1];
`endif
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = step_vec[STEP_W-1:WIDTH];
                shift_d   = step_vec[WIDTH-1:0];
                // Counter saturates so it can never wrap past WIDTH.
                if (cnt_q != MAX_STEP) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Publish the fully shifted result straight from this step so
                // bcd never exposes a partial value.
                if (cnt_q == LAST_STEP) begin
                    bcd_d       = step_vec[STEP_W-1:WIDTH];
                    out_valid_d = 1'b1;
`ifdef BCD_SIGNED_EN
                    negative_d  = sign_q;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q      <= 1'b0;
            negative_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_SIGNED_EN
            sign_q      <= sign_d;
            negative_q  <= negative_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
`ifdef BCD_SIGNED_EN
    assign bus.negative  = negative_q;
`else
    assign bus.negative  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Directed self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled at the same point.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept v on the next edge, then wait (bounded) for the out_valid pulse.
    // lat is the number of edges from the accepting edge, -1 on timeout.
    task automatic run_conv(input logic [7:0] v, output logic [11:0] b,
                            output logic n, output int lat);
        bus.number   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        b   = 12'h000;
        n   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                b   = bus.bcd;
                n   = bus.negative;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.number   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", bus.bcd); end
        checks++; if (bus.negative !== 1'b0) begin errors++; $display("FAIL reset_negative got=%b exp=0", bus.negative); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max_value;
        logic [11:0] b; logic n; int lat;
        run_conv(8'd255, b, n, lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL t255_latency got=%0d exp=8", lat); end
        checks++; if (b !== 12'h255) begin errors++; $display("FAIL t255_bcd got=%h exp=255", b); end
        checks++; if (n !== 1'b0) begin errors++; $display("FAIL t255_negative got=%b exp=0", n); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t255_busy_done got=%b exp=0", bus.busy); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t255_pulse_width got=%b exp=0", bus.out_valid); end
        checks++; if (bus.bcd !== 12'h255) begin errors++; $display("FAIL t255_hold got=%h exp=255", bus.bcd); end
    endtask

    task automatic test_back_to_back;
        int pulses; int k1; int k2; logic [11:0] b1; logic [11:0] b2; logic rdy8;
        pulses = 0; k1 = -1; k2 = -1; b1 = 12'hfff; b2 = 12'hfff; rdy8 = 1'b0;
        bus.number   = 8'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.number = 8'd100;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (k == 8) rdy8 = bus.in_ready;
            if (bus.out_valid) begin
                pulses++;
                if (pulses == 1) begin k1 = k; b1 = bus.bcd; end
                else if (pulses == 2) begin k2 = k; b2 = bus.bcd; end
            end
            // The second value is accepted on the edge right after the first
            // pulse (k=9); release in_valid once past it.
            if (k == 9) bus.in_valid = 1'b0;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (k1 != 8 || b1 !== 12'h000) begin errors++; $display("FAIL b2b_first got=k%0d/%h exp=k8/000", k1, b1); end
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got=%b exp=1", rdy8); end
        checks++; if (k2 != 17 || b2 !== 12'h100) begin errors++; $display("FAIL b2b_second got=k%0d/%h exp=k17/100", k2, b2); end
    endtask

    task automatic test_busy_ignore;
        int ready_bad; int lat; logic [11:0] b; int extra;
        ready_bad = 0; lat = -1; b = 12'hfff; extra = 0;
        bus.number   = 8'd42;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin lat = k; b = bus.bcd; break; end
            if (bus.in_ready !== 1'b0) ready_bad++;
            if (k == 2) begin bus.number = 8'd99; bus.in_valid = 1'b1; end
            if (k == 6) bus.in_valid = 1'b0;
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL busy_in_ready got=%0d_high_cycles exp=0", ready_bad); end
        checks++; if (lat != 8) begin errors++; $display("FAIL busy_latency got=%0d exp=8", lat); end
        checks++; if (b !== 12'h042) begin errors++; $display("FAIL busy_bcd got=%h exp=042", b); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_no_99 got=%0d_pulses exp=0", extra); end
        checks++; if (bus.bcd !== 12'h042) begin errors++; $display("FAIL busy_hold got=%h exp=042", bus.bcd); end
    endtask

    task automatic test_reset_mid;
        int extra; logic [11:0] b; logic n; int lat;
        extra = 0;
        bus.number   = 8'd200;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.bcd !== 12'h000) begin errors++; $display("FAIL abort_bcd got=%h exp=000", bus.bcd); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b/%b exp=1/0", bus.in_ready, bus.busy); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL abort_no_result got=%0d_pulses exp=0", extra); end
        run_conv(8'd7, b, n, lat);
        checks++; if (lat != 8 || b !== 12'h007) begin errors++; $display("FAIL after_abort got=lat%0d/%h exp=lat8/007", lat, b); end
    endtask

    task automatic test_sign;
        logic [7:0]  vin  [3];
        logic [11:0] vbcd [3];
        logic        vneg [3];
        logic [11:0] b; logic n; int lat;
        vin[0] = 8'hFF; vin[1] = 8'h80; vin[2] = 8'h7F;
`ifdef BCD_SIGNED_EN
        vbcd[0] = 12'h001; vneg[0] = 1'b1;
        vbcd[1] = 12'h128; vneg[1] = 1'b1;
        vbcd[2] = 12'h127; vneg[2] = 1'b0;
`else
        vbcd[0] = 12'h255; vneg[0] = 1'b0;
        vbcd[1] = 12'h128; vneg[1] = 1'b0;
        vbcd[2] = 12'h127; vneg[2] = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            run_conv(vin[i], b, n, lat);
            checks++;
            if (lat != 8 || b !== vbcd[i] || n !== vneg[i]) begin
                errors++;
                $display("FAIL sign_%h got=lat%0d/%h/neg%b exp=lat8/%h/neg%b", vin[i], lat, b, n, vbcd[i], vneg[i]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [11:0] b; logic n; int lat; int m; logic [11:0] exp_b; logic exp_n;
        for (int v = 0; v < 256; v++) begin
`ifdef BCD_SIGNED_EN
            m     = (v >= 128) ? (256 - v) : v;
            exp_n = (v >= 128);
`else
            m     = v;
            exp_n = 1'b0;
`endif
            exp_b = {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
            run_conv(8'(v), b, n, lat);
            checks++;
            if (lat != 8 || b !== exp_b || n !== exp_n) begin
                errors++;
                $display("FAIL sweep_%0d got=lat%0d/%h/neg%b exp=lat8/%h/neg%b", v, lat, b, n, exp_b, exp_n);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max_value();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_sign();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
